// File: rtl/alu_md_pkg.sv
// Shared opcodes and FSM encoding for the alu_md execute unit.
package alu_md_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_SHL   = 5'd0;
    localparam logic [OP_W-1:0] OP_SHR   = 5'd1;
    localparam logic [OP_W-1:0] OP_SAR   = 5'd2;
    localparam logic [OP_W-1:0] OP_ADD   = 5'd3;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd4;
    localparam logic [OP_W-1:0] OP_AND   = 5'd5;
    localparam logic [OP_W-1:0] OP_OR    = 5'd6;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd7;
    localparam logic [OP_W-1:0] OP_NOR   = 5'd8;
    localparam logic [OP_W-1:0] OP_SLT   = 5'd9;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'd10;
    localparam logic [OP_W-1:0] OP_MULT  = 5'd11;
    localparam logic [OP_W-1:0] OP_MULTU = 5'd12;
    localparam logic [OP_W-1:0] OP_DIV   = 5'd13;
    localparam logic [OP_W-1:0] OP_DIVU  = 5'd14;
    localparam logic [OP_W-1:0] OP_MFHI  = 5'd15;
    localparam logic [OP_W-1:0] OP_MFLO  = 5'd16;
    localparam logic [OP_W-1:0] OP_MTHI  = 5'd17;
    localparam logic [OP_W-1:0] OP_MTLO  = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_md_op(input logic [OP_W-1:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply (shift-add) / divide (restoring) on operand magnitudes,
// with sign correction applied to the final step's values.
module alu_md_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             done_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             running;
    logic             div_mode;
    logic             neg_main;
    logic             neg_rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] mag;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]   qr_n;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        a_neg = is_signed & srca[WIDTH-1];
        b_neg = is_signed & srcb[WIDTH-1];
        a_abs = a_neg ? (-srca) : srca;
        b_abs = b_neg ? (-srcb) : srcb;
    end

    // One step: acc is the running HI / partial remainder, qr the multiplier / quotient.
    always_comb begin
        mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, mag} : '0);
        div_sh   = {acc, qr[WIDTH-1]};
        div_diff = div_sh - {1'b0, mag};
        if (div_mode) begin
            acc_n = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            qr_n  = {qr[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            qr_n  = {mul_sum[0], qr[WIDTH-1:1]};
        end
        prod     = {acc_n, qr_n};
        prod_fix = neg_main ? (-prod) : prod;
        done_c   = running & (cnt == '0);
        if (div_mode) begin
            hi_c = neg_rem  ? (-acc_n) : acc_n;
            lo_c = neg_main ? (-qr_n)  : qr_n;
        end else begin
            hi_c = prod_fix[2*WIDTH-1:WIDTH];
            lo_c = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            running  <= 1'b0;
            div_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            qr       <= '0;
            mag      <= '0;
        end else if (start) begin
            running  <= 1'b1;
            div_mode <= is_div;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            cnt      <= CW'(WIDTH - 1);
            acc      <= '0;
            qr       <= a_abs;
            mag      <= b_abs;
        end else if (running) begin
            acc <= acc_n;
            qr  <= qr_n;
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// Registered ALU with iterative multiply/divide into HI/LO and a valid/ready handshake.
// Optional signed-overflow output for add/sub when ALU_MD_OVF_EN is defined.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [4:0]       aluop_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] alu_result_o,
    output logic             zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
`ifdef ALU_MD_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    state_t state;

    logic             accept;
    logic             md_op;
    logic             div_op;
    logic             div0;
    logic             it_start;
    logic             it_signed;
    logic             it_done_c;
    logic [WIDTH-1:0] it_hi_c;
    logic [WIDTH-1:0] it_lo_c;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] simple_res;
    logic             simple_def;
    logic             simple_zero;

    always_comb begin
        accept    = (state == ST_IDLE) & valid_i;
        md_op     = is_md_op(aluop_i);
        div_op    = (aluop_i == OP_DIV) | (aluop_i == OP_DIVU);
        div0      = div_op & (srcb_i == '0);
        it_start  = accept & md_op & ~div0;
        it_signed = (aluop_i == OP_MULT) | (aluop_i == OP_DIV);
    end

    // Single-cycle ops; undefined opcodes yield 0 with zero_o held low.
    always_comb begin
        shamt      = srca_i[SHW-1:0];
        add_res    = srca_i + srcb_i;
        sub_res    = srca_i - srcb_i;
        simple_res = '0;
        simple_def = 1'b1;
        case (aluop_i)
            OP_SHL:  simple_res = srcb_i << shamt;
            OP_SHR:  simple_res = srcb_i >> shamt;
            OP_SAR:  simple_res = WIDTH'($signed(srcb_i) >>> shamt);
            OP_ADD:  simple_res = add_res;
            OP_SUB:  simple_res = sub_res;
            OP_AND:  simple_res = srca_i & srcb_i;
            OP_OR:   simple_res = srca_i | srcb_i;
            OP_XOR:  simple_res = srca_i ^ srcb_i;
            OP_NOR:  simple_res = ~(srca_i | srcb_i);
            OP_SLT:  simple_res = WIDTH'($signed(srca_i) < $signed(srcb_i));
            OP_SLTU: simple_res = WIDTH'(srca_i < srcb_i);
            OP_MFHI: simple_res = hi_o;
            OP_MFLO: simple_res = lo_o;
            default: simple_def = 1'b0;
        endcase
        simple_zero = simple_def & (simple_res == '0);
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (it_start),
        .is_signed (it_signed),
        .is_div    (div_op),
        .srca      (srca_i),
        .srcb      (srcb_i),
        .done_c    (it_done_c),
        .hi_c      (it_hi_c),
        .lo_c      (it_lo_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            ready_o        <= 1'b1;
            busy_o         <= 1'b0;
            result_valid_o <= 1'b0;
            alu_result_o   <= '0;
            zero_o         <= 1'b0;
            hi_o           <= '0;
            lo_o           <= '0;
        end else begin
            result_valid_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (md_op && div0) begin
                            hi_o           <= srca_i;
                            lo_o           <= '1;
                            alu_result_o   <= '1;
                            zero_o         <= 1'b0;
                            result_valid_o <= 1'b1;
                            ready_o        <= 1'b0;
                            state          <= ST_DONE;
                        end else if (md_op) begin
                            ready_o <= 1'b0;
                            busy_o  <= 1'b1;
                            state   <= ST_RUN;
                        end else if (aluop_i == OP_MTHI || aluop_i == OP_MTLO) begin
                            if (aluop_i == OP_MTHI) begin
                                hi_o <= srca_i;
                            end else begin
                                lo_o <= srca_i;
                            end
                            alu_result_o   <= srca_i;
                            zero_o         <= (srca_i == '0);
                            result_valid_o <= 1'b1;
                        end else begin
                            alu_result_o   <= simple_res;
                            zero_o         <= simple_zero;
                            result_valid_o <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (it_done_c) begin
                        hi_o           <= it_hi_c;
                        lo_o           <= it_lo_c;
                        alu_result_o   <= it_lo_c;
                        zero_o         <= (it_lo_c == '0);
                        result_valid_o <= 1'b1;
                        busy_o         <= 1'b0;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready_o <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_MD_OVF_EN
    logic add_ovf;
    logic sub_ovf;
    logic ovf_c;
    logic res_wr;

    // Overflow is updated whenever alu_result_o is written, so it always describes that result.
    always_comb begin
        add_ovf = (srca_i[WIDTH-1] == srcb_i[WIDTH-1]) & (add_res[WIDTH-1] != srca_i[WIDTH-1]);
        sub_ovf = (srca_i[WIDTH-1] != srcb_i[WIDTH-1]) & (sub_res[WIDTH-1] != srca_i[WIDTH-1]);
        ovf_c   = accept & (((aluop_i == OP_ADD) & add_ovf) | ((aluop_i == OP_SUB) & sub_ovf));
        res_wr  = (accept & ~it_start) | ((state == ST_RUN) & it_done_c);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (res_wr) begin
            overflow_o <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed cases plus random ops against a cycle-level model.
module tb_alu_md;
    import alu_md_pkg::*;

    localparam int unsigned W = 32;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         valid = 1'b0;
    logic [4:0]   aluop = '0;
    logic [W-1:0] srca  = '0;
    logic [W-1:0] srcb  = '0;
    logic         ready;
    logic         busy;
    logic         rv;
    logic [W-1:0] res;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef ALU_MD_OVF_EN
    logic         ovf;
`endif

    alu_md #(.WIDTH(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .valid_i        (valid),
        .aluop_i        (aluop),
        .srca_i         (srca),
        .srcb_i         (srcb),
        .ready_o        (ready),
        .busy_o         (busy),
        .result_valid_o (rv),
        .alu_result_o   (res),
        .zero_o         (zero),
        .hi_o           (hi),
        .lo_o           (lo)
`ifdef ALU_MD_OVF_EN
        ,
        .overflow_o     (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    bit checking = 1'b0;

    // Model state: absolute cycle numbers of the pending result and the end of stall windows.
    int           res_cycle  = -1;
    int           rdy_until  = -1;
    int           busy_until = -1;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic [W-1:0] p_hi = '0, p_lo = '0, p_res = '0;
    bit           p_zero = 1'b0, p_ovf = 1'b0;
    logic [W-1:0] exp_res = '0;
    bit           exp_zero = 1'b0, exp_ovf = 1'b0, exp_rv = 1'b0;
    bit           exp_ready = 1'b1, exp_busy = 1'b0;

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result of one op: value, new HI/LO, and timing (result cycle, stall, busy).
    function automatic void model_op(
        input  logic [4:0]   op,
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic [W-1:0] hi_in,
        input  logic [W-1:0] lo_in,
        output logic [W-1:0] r,
        output logic [W-1:0] nhi,
        output logic [W-1:0] nlo,
        output bit           z,
        output bit           ov,
        output int           lat,
        output int           rlow,
        output int           bsy
    );
        longint             sa, sb, s, lim_hi, lim_lo;
        logic signed [63:0] sp;
        logic [63:0]        up;
        bit                 def;
        bit                 md;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lim_hi = 2147483647;
        lim_lo = -lim_hi - 1;
        nhi = hi_in; nlo = lo_in; r = '0; ov = 1'b0;
        lat = 1; rlow = 0; bsy = 0; def = 1'b1; md = 1'b0;
        case (op)
            OP_SHL:  r = b << a[4:0];
            OP_SHR:  r = b >> a[4:0];
            OP_SAR:  r = $signed(b) >>> a[4:0];
            OP_ADD:  begin r = a + b; s = sa + sb; ov = (s > lim_hi) || (s < lim_lo); end
            OP_SUB:  begin r = a - b; s = sa - sb; ov = (s > lim_hi) || (s < lim_lo); end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = (sa < sb) ? 1 : 0;
            OP_SLTU: r = (a < b) ? 1 : 0;
            OP_MULT: begin
                sp = sa * sb; nhi = sp[63:32]; nlo = sp[31:0]; md = 1'b1;
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b}; nhi = up[63:32]; nlo = up[31:0]; md = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    nhi = a; nlo = '1; rlow = 1;
                end else begin
                    md = 1'b1;
                    if (op == OP_DIV) begin
                        sp = sa / sb; nlo = sp[31:0];
                        sp = sa % sb; nhi = sp[31:0];
                    end else begin
                        nlo = a / b; nhi = a % b;
                    end
                end
                r = nlo;
            end
            OP_MFHI: r = hi_in;
            OP_MFLO: r = lo_in;
            OP_MTHI: begin nhi = a; r = a; end
            OP_MTLO: begin nlo = a; r = a; end
            default: def = 1'b0;
        endcase
        if (op == OP_MULT || op == OP_MULTU) r = nlo;
        if (md) begin
            lat = W + 1; rlow = W + 1; bsy = W;
        end
        z = def && (r == '0);
    endfunction

    task automatic model_reset();
        res_cycle = -1; rdy_until = -1; busy_until = -1;
        m_hi = '0; m_lo = '0;
        exp_res = '0; exp_zero = 1'b0; exp_ovf = 1'b0; exp_rv = 1'b0;
        exp_ready = 1'b1; exp_busy = 1'b0;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        exp_rv = (cyc == res_cycle);
        if (exp_rv) begin
            exp_res = p_res; exp_zero = p_zero; exp_ovf = p_ovf;
            m_hi = p_hi; m_lo = p_lo;
        end
        exp_ready = (cyc > rdy_until);
        exp_busy  = (cyc <= busy_until);
    endtask

    task automatic step(input bit v, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, rlow, bsy;
        valid = v; aluop = op; srca = a; srcb = b;
        if (v && exp_ready && !rst) begin
            model_op(op, a, b, m_hi, m_lo, p_res, p_hi, p_lo, p_zero, p_ovf, lat, rlow, bsy);
            res_cycle  = cyc + lat;
            rdy_until  = cyc + rlow;
            busy_until = cyc + bsy;
        end
        advance();
    endtask

    // Steps with a competing request until the result pulse; returns the cycle index it arrived on.
    task automatic wait_rv(output int n);
        n = 1;
        while (!rv && n < 100) begin
            step(1'b1, OP_ADD, 32'd1, 32'd2);
            n++;
        end
    endtask

    task automatic mid_reset();
        valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        cmp("rst_ready", 32'(ready), 32'd1);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_rv", 32'(rv), 32'd0);
        cmp("rst_hi", hi, 32'd0);
        cmp("rst_lo", lo, 32'd0);
        advance();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            cmp("ready", 32'(ready), 32'(exp_ready));
            cmp("busy", 32'(busy), 32'(exp_busy));
            cmp("result_valid", 32'(rv), 32'(exp_rv));
            cmp("alu_result", res, exp_res);
            cmp("zero", 32'(zero), 32'(exp_zero));
            cmp("hi", hi, m_hi);
            cmp("lo", lo, m_lo);
`ifdef ALU_MD_OVF_EN
            cmp("overflow", 32'(ovf), 32'(exp_ovf));
`endif
        end
    end

    initial begin
        logic [W-1:0] t_r, t_hi, t_lo;
        bit           t_z, t_ov;
        int           t_lat, t_rlow, t_bsy, n;
        logic [4:0]   rop;

        // Hand-computed values that pin the reference model.
        model_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, '0, '0, t_r, t_hi, t_lo, t_z, t_ov, t_lat, t_rlow, t_bsy);
        cmp("model_mult_hi", t_hi, 32'hFFFF_FFFF);
        cmp("model_mult_lo", t_lo, 32'hFFFF_FFEB);
        cmp("model_mult_lat", 32'(t_lat), 32'd33);
        model_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, '0, t_r, t_hi, t_lo, t_z, t_ov, t_lat, t_rlow, t_bsy);
        cmp("model_div_lo", t_lo, 32'hFFFF_FFFD);
        cmp("model_div_hi", t_hi, 32'hFFFF_FFFF);
        model_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, t_r, t_hi, t_lo, t_z, t_ov, t_lat, t_rlow, t_bsy);
        cmp("model_divovf_lo", t_lo, 32'h8000_0000);
        cmp("model_divovf_hi", t_hi, 32'h0000_0000);
        model_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, '0, '0, t_r, t_hi, t_lo, t_z, t_ov, t_lat, t_rlow, t_bsy);
        cmp("model_add_res", t_r, 32'h8000_0000);
        cmp("model_add_ovf", 32'(t_ov), 32'd1);
        model_op(OP_SAR, 32'd4, 32'h8000_0000, '0, '0, t_r, t_hi, t_lo, t_z, t_ov, t_lat, t_rlow, t_bsy);
        cmp("model_sar", t_r, 32'hF800_0000);

        // Reset state
        rst = 1'b1;
        advance();
        advance();
        checking = 1'b1;
        advance();
        rst = 1'b0;

        step(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
        cmp("add_res", res, 32'h8000_0000);
        cmp("add_zero", 32'(zero), 32'd0);
`ifdef ALU_MD_OVF_EN
        cmp("add_ovf", 32'(ovf), 32'd1);
`endif
        step(1'b1, OP_SUB, 32'd5, 32'd5);
        cmp("sub_res", res, 32'd0);
        cmp("sub_zero", 32'(zero), 32'd1);
        step(1'b1, OP_SAR, 32'd4, 32'h8000_0000);
        cmp("sar_res", res, 32'hF800_0000);
        step(1'b1, OP_SHL, 32'd33, 32'd1);
        cmp("shl_res", res, 32'h0000_0002);

        step(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_rv(n);
        cmp("mult_latency", 32'(n), 32'd33);
        cmp("mult_hi", hi, 32'hFFFF_FFFF);
        cmp("mult_lo", lo, 32'hFFFF_FFEB);
        step(1'b0, OP_ADD, '0, '0);

        step(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_rv(n);
        cmp("div_lo", lo, 32'hFFFF_FFFD);
        cmp("div_hi", hi, 32'hFFFF_FFFF);
        step(1'b0, OP_ADD, '0, '0);

        step(1'b1, OP_DIVU, 32'd7, 32'd0);
        cmp("div0_rv", 32'(rv), 32'd1);
        cmp("div0_lo", lo, 32'hFFFF_FFFF);
        cmp("div0_hi", hi, 32'd7);
        step(1'b0, OP_ADD, '0, '0);

        step(1'b1, OP_MTHI, 32'h0000_1234, 32'd0);
        step(1'b1, OP_MFHI, 32'd0, 32'd0);
        cmp("mfhi_res", res, 32'h0000_1234);

        step(1'b1, OP_MULTU, 32'd5, 32'd6);
        repeat (5) step(1'b0, OP_ADD, '0, '0);
        mid_reset();
        repeat (40) step(1'b0, OP_ADD, '0, '0);

        // Random traffic, including requests while busy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                mid_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) rop = 5'($urandom_range(19, 31));
                else rop = 5'($urandom_range(0, 18));
                step($urandom_range(0, 4) != 0, rop, rand_val(), rand_val());
            end
        end
        repeat (40) step(1'b0, OP_ADD, '0, '0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
